// File: rtl/sipo_register.sv
// Serial-in, parallel-out shift register: one bit captured per rising CLK edge, last WIDTH bits on Q.
// Optional build macro SIPO_FRAME_EN adds a word counter and a one-cycle WORD_VALID pulse per aligned word.
module sipo_register #(
  parameter int WIDTH      = 4,
  parameter bit SHIFT_LEFT = 1'b1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             IN,
`ifdef SIPO_FRAME_EN
  output logic             WORD_VALID,
`endif
  output logic [WIDTH-1:0] Q
);

  logic [WIDTH-1:0] sr_q;
  logic [WIDTH-1:0] sr_d;

  generate
    if (SHIFT_LEFT) begin : g_left
      always_comb begin
        sr_d = {sr_q[WIDTH-2:0], IN};
      end
    end else begin : g_right
      always_comb begin
        sr_d = {IN, sr_q[WIDTH-1:1]};
      end
    end
  endgenerate

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign Q = sr_q;

`ifdef SIPO_FRAME_EN
  localparam int CW = $clog2(WIDTH);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          word_valid_q;
  logic          word_valid_d;

  // The edge that sees cnt_q at WIDTH-1 captures the last bit of an aligned word.
  always_comb begin
    cnt_d        = cnt_q + CW'(1);
    word_valid_d = 1'b0;
    if (cnt_q == CW'(WIDTH - 1)) begin
      cnt_d        = '0;
      word_valid_d = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cnt_q        <= '0;
      word_valid_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      word_valid_q <= word_valid_d;
    end
  end

  assign WORD_VALID = word_valid_q;
`endif

endmodule

// File: tb/tb_sipo_register.sv
// Bench for sipo_register: three instances (left/right shift, odd width) against a bit-history model.
// Also exercises WORD_VALID when built with SIPO_FRAME_EN.
module tb_sipo_register;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       IN  = 1'b0;
  logic [3:0] qL;
  logic [3:0] qR;
  logic [6:0] qW;
`ifdef SIPO_FRAME_EN
  logic       wvL, wvR, wvW;
`endif

  int nChecks = 0;
  int nFails  = 0;

  // Newest captured bit at index 0; nShifts counts edges since reset release.
  logic hist[$];
  int   nShifts = 0;

  always #5 CLK = ~CLK;

  sipo_register #(.WIDTH(4), .SHIFT_LEFT(1'b1)) dutL (
    .CLK(CLK), .RST(RST), .IN(IN),
`ifdef SIPO_FRAME_EN
    .WORD_VALID(wvL),
`endif
    .Q(qL));

  sipo_register #(.WIDTH(4), .SHIFT_LEFT(1'b0)) dutR (
    .CLK(CLK), .RST(RST), .IN(IN),
`ifdef SIPO_FRAME_EN
    .WORD_VALID(wvR),
`endif
    .Q(qR));

  sipo_register #(.WIDTH(7), .SHIFT_LEFT(1'b1)) dutW (
    .CLK(CLK), .RST(RST), .IN(IN),
`ifdef SIPO_FRAME_EN
    .WORD_VALID(wvW),
`endif
    .Q(qW));

  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      hist.delete();
      nShifts = 0;
    end else begin
      hist.push_front(IN);
      if (hist.size() > 64) void'(hist.pop_back());
      nShifts++;
    end
  end

  function automatic logic [63:0] expQ(input int w, input bit left);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < w; i++) begin
      if (i < hist.size()) r[left ? i : w - 1 - i] = hist[i];
    end
    return r;
  endfunction

  function automatic logic expValid(input int w);
    return (nShifts != 0) && (nShifts % w == 0);
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge CLK) begin
    checkOutput("model qL", 64'(qL), expQ(4, 1'b1));
    checkOutput("model qR", 64'(qR), expQ(4, 1'b0));
    checkOutput("model qW", 64'(qW), expQ(7, 1'b1));
`ifdef SIPO_FRAME_EN
    checkOutput("model wvL", 64'(wvL), 64'(expValid(4)));
    checkOutput("model wvR", 64'(wvR), 64'(expValid(4)));
    checkOutput("model wvW", 64'(wvW), 64'(expValid(7)));
`endif
  end

  task automatic applyStimulus(input logic b);
    IN = b;
    @(posedge CLK);
    #1;
  endtask

  task automatic step(input logic b, input logic [3:0] eL, input logic [3:0] eR, input string tag);
    applyStimulus(b);
    checkOutput({tag, " qL"}, 64'(qL), 64'(eL));
    checkOutput({tag, " qR"}, 64'(qR), 64'(eR));
  endtask

  // Asserts reset between edges, checks the immediate clear, holds across one edge, releases.
  task automatic doReset(input string tag);
    #2;
    RST = 1'b0;
    #1;
    checkOutput({tag, " async qL"}, 64'(qL), 64'd0);
    checkOutput({tag, " async qR"}, 64'(qR), 64'd0);
    @(posedge CLK);
    #1;
    RST = 1'b1;
  endtask

  logic [7:0] frameBits = 8'b1011_0010;
  logic [3:0] frameL[8] = '{4'b0001, 4'b0010, 4'b0101, 4'b1011, 4'b0110, 4'b1100, 4'b1001, 4'b0010};
  logic [3:0] frameR[8] = '{4'b1000, 4'b0100, 4'b1010, 4'b1101, 4'b0110, 4'b0011, 4'b1001, 4'b0100};

  initial begin
    RST = 1'b0;
    IN  = 1'b0;
    repeat (5) @(posedge CLK);
    #1;
    checkOutput("reset qL", 64'(qL), 64'd0);
    checkOutput("reset qR", 64'(qR), 64'd0);
    checkOutput("reset qW", 64'(qW), 64'd0);
`ifdef SIPO_FRAME_EN
    checkOutput("reset wvL", 64'(wvL), 64'd0);
`endif
    @(posedge CLK);
    #1;
    RST = 1'b1;

    step(1'b0, 4'b0000, 4'b0000, "stream0");
    step(1'b1, 4'b0001, 4'b1000, "stream1");
    step(1'b0, 4'b0010, 4'b0100, "stream2");
    step(1'b1, 4'b0101, 4'b1010, "stream3");
    step(1'b0, 4'b1010, 4'b0101, "discard0");
    step(1'b0, 4'b0100, 4'b0010, "discard1");

    doReset("rst1");
    step(1'b0, 4'b0000, 4'b0000, "refill0");
    step(1'b1, 4'b0001, 4'b1000, "refill1");
    step(1'b0, 4'b0010, 4'b0100, "refill2");
    step(1'b1, 4'b0101, 4'b1010, "refill3");
    doReset("midstream");
    step(1'b1, 4'b0001, 4'b1000, "restart");

    doReset("rst2");
    step(1'b1, 4'b0001, 4'b1000, "right0");
    step(1'b0, 4'b0010, 4'b0100, "right1");
    step(1'b0, 4'b0100, 4'b0010, "right2");
    step(1'b0, 4'b1000, 4'b0001, "right3");

    doReset("rst3");
    for (int i = 0; i < 8; i++) begin
      step(frameBits[7 - i], frameL[i], frameR[i], $sformatf("frame%0d", i + 1));
`ifdef SIPO_FRAME_EN
      checkOutput($sformatf("frame%0d wvL", i + 1), 64'(wvL), 64'((i == 3) || (i == 7)));
      checkOutput($sformatf("frame%0d wvW", i + 1), 64'(wvW), 64'(i == 6));
`endif
    end

    for (int i = 0; i < 40; i++) begin
      applyStimulus(1'($urandom_range(0, 1)));
    end

    @(negedge CLK);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/sipo_register.md
# sipo_register

Serial-in, parallel-out shift register. It captures one serial bit per rising clock edge and presents the last WIDTH captured bits on a parallel bus. It sits at the receive side of a serial link or bit-stream interface, ahead of logic that consumes whole words.

## Interface
Parameters:
- WIDTH, 4: parallel output width in bits; legal range 2..64.
- SHIFT_LEFT, 1: 1 means IN enters Q[0] and data moves toward Q[WIDTH-1]. 0 means IN enters Q[WIDTH-1] and data moves toward Q[0].

Ports (one clock; reset is asynchronous and active-low):
- CLK  input  1  clock; all state updates on the rising edge.
- RST  input  1  asynchronous, active-low reset; clears all state immediately.
- IN  input  1  serial data bit, sampled on each rising CLK edge.
- Q  output  WIDTH  parallel view of the shift register, driven directly from flops.
- WORD_VALID  output  1  present only with SIPO_FRAME_EN; see Configuration.

## Operation
- Internal state is a WIDTH-bit register sr. Q equals sr at all times, with no combinational path from IN to Q.
- Shift rule when SHIFT_LEFT=1: sr <= {sr[WIDTH-2:0], IN}.
- Shift rule when SHIFT_LEFT=0: sr <= {IN, sr[WIDTH-1:1]}.
- A shift happens on every rising CLK edge while RST=1. There is no enable and no hold state.
- The oldest bit is discarded off the far end of the register. There is no overflow indication.
- IN may change at any time relative to CLK. Only the value present at the rising edge, within setup/hold, is captured.
- X on IN is shifted in as-is. The block does no filtering.

## Timing
- Reset: while RST=0, Q=0 (and WORD_VALID=0 when configured). This takes effect asynchronously, with no clock required.
- Reset release: the first rising CLK edge with RST=1 performs the first shift. Reset deassertion is synchronized externally; this block adds no synchronizer.
- Latency: a bit sampled at edge n appears in Q[0] (SHIFT_LEFT=1) just after edge n. It reaches Q[WIDTH-1] after edge n+WIDTH-1.
- A full new word is present in Q WIDTH edges after its first bit was sampled.
- Reset mid-stream: Q clears at once and any partial word is lost. Shifting restarts from zero on the next edge after release.
- Reset asserted in the same edge window as CLK: reset wins, and Q=0.

## Configuration
- Macro SIPO_FRAME_EN.
- Defined: add a bit counter of width clog2(WIDTH) and the WORD_VALID output.
  - The counter increments on every shift and wraps from WIDTH-1 to 0.
  - WORD_VALID is a registered pulse of exactly one cycle. It is high for the cycle after the edge that captured bit number WIDTH, 2*WIDTH, and so on, counted from reset release.
  - While WORD_VALID is high, Q holds a complete aligned word.
  - Reset clears the counter to 0 and WORD_VALID to 0.
- Undefined: no counter and no WORD_VALID port. Q behaviour is identical in both builds.

## Test plan
- Assert RST=0 for 50 ns with CLK running -> Q=0000 throughout. With SIPO_FRAME_EN, WORD_VALID=0.
- WIDTH=4, SHIFT_LEFT=1: release reset and drive IN=0,1,0,1 on four consecutive edges -> Q reads 0000, 0001, 0010, 0101.
- Continue the previous stream with IN=0,0 -> Q reads 1010, then 0100, showing the oldest bits discarded.
- Assert RST=0 asynchronously between edges while Q=0101 -> Q=0000 immediately, before the next CLK edge. Then drive IN=1 for one edge after release -> Q=0001.
- SHIFT_LEFT=0, WIDTH=4: drive IN=1,0,0,0 -> Q reads 1000, 0100, 0010, 0001.
- With SIPO_FRAME_EN, stream 8 bits 1,0,1,1,0,0,1,0 after reset:
  - WORD_VALID pulses high for one cycle after edge 4 with Q=1011.
  - It pulses again after edge 8 with Q=0010.
  - It is low on all other cycles.
